// File: rtl/fcomp_pipe_pkg.sv
// Shared types for the fcomp_pipe compare/select unit: opcodes, width helper,
// canonical quiet-NaN generator and the stage-1 pipeline payload.
package fcomp_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcomp_op_e;

  // Payload fields are sized for the widest supported format; unused upper bits stay zero.
  localparam int XW_MAX  = 64;
  localparam int TAG_MAX = 16;

  function automatic int fcomp_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic logic [XW_MAX-1:0] fcomp_qnan(input int exp_w, input int man_w);
    logic [XW_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

  typedef struct packed {
    logic [2:0]         op;
    logic [XW_MAX-1:0]  x1;
    logic [XW_MAX-1:0]  x2;
    logic [TAG_MAX-1:0] tag;
    logic               zc;
    logic               mlt;
  } fcomp_pay_t;

endpackage

// File: rtl/fcomp_pipe_if.sv
// Request/response bundle for fcomp_pipe. nv_out exists only when FCOMP_NAN_EN is defined.
interface fcomp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = fcomp_pkg::fcomp_w(EXP_W, MAN_W);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [W-1:0]     x1;
  logic [W-1:0]     x2;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y;
  logic [TAG_W-1:0] tag_out;
`ifdef FCOMP_NAN_EN
  logic             nv_out;

  modport master (output in_valid, op, x1, x2, tag_in, out_ready,
                  input  in_ready, out_valid, y, tag_out, nv_out);
  modport slave  (input  in_valid, op, x1, x2, tag_in, out_ready,
                  output in_ready, out_valid, y, tag_out, nv_out);
`else
  modport master (output in_valid, op, x1, x2, tag_in, out_ready,
                  input  in_ready, out_valid, y, tag_out);
  modport slave  (input  in_valid, op, x1, x2, tag_in, out_ready,
                  output in_ready, out_valid, y, tag_out);
`endif
endinterface

// File: rtl/fcomp_pipe_core.sv
// Combinational classify / compare / select datapath of fcomp_pipe, split into three
// independent sections so the top can place stage registers between them. FCOMP_NAN_EN adds NaN handling.
module fcomp_core
  import fcomp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = fcomp_w(EXP_W, MAN_W)
) (
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
  output logic         zc_o,
  output logic         mlt_o,
  input  fcomp_pay_t   cp_i,
  output logic         eq_o,
  output logic         lt_o,
  input  fcomp_pay_t   sp_i,
  input  logic         eq_i,
  input  logic         lt_i,
`ifdef FCOMP_NAN_EN
  output logic         nv_o,
`endif
  output logic [W-1:0] y_o
);

  logic unused_pay;
  assign unused_pay = ^{cp_i, sp_i};

  assign zc_o  = ~|x1_i[W-2:MAN_W] & ~|x2_i[W-2:MAN_W];
  assign mlt_o = x1_i[W-2:0] < x2_i[W-2:0];

  logic [W-1:0] ca, cb, sa, sb;
  logic         c_same, c_nan, s_le;
  assign ca = cp_i.x1[W-1:0];
  assign cb = cp_i.x2[W-1:0];
  assign sa = sp_i.x1[W-1:0];
  assign sb = sp_i.x2[W-1:0];
  assign c_same = (ca == cb);

`ifdef FCOMP_NAN_EN
  localparam logic [W-1:0] QNAN = W'(fcomp_qnan(EXP_W, MAN_W));

  function automatic logic is_nan(input logic [W-1:0] v);
    return (&v[W-2:MAN_W]) & (|v[MAN_W-1:0]);
  endfunction

  logic s_na, s_nb;
  assign c_nan = is_nan(ca) | is_nan(cb);
  assign s_na  = is_nan(sa);
  assign s_nb  = is_nan(sb);
  // Quiet bit is the mantissa MSB; signalling NaNs always raise invalid.
  assign nv_o  = (s_na & ~sa[MAN_W-1]) | (s_nb & ~sb[MAN_W-1])
               | (((sp_i.op == FLT) | (sp_i.op == FLE)) & (s_na | s_nb));
`else
  assign c_nan = 1'b0;
`endif

  always_comb begin
    logic lt_raw;
    lt_raw = 1'b0;
    if (cp_i.zc)                lt_raw = 1'b0;
    else if (ca[W-1] != cb[W-1]) lt_raw = ca[W-1];
    else if (ca[W-1])            lt_raw = ~cp_i.mlt & ~c_same;
    else                         lt_raw = cp_i.mlt;
    eq_o = (cp_i.zc | c_same) & ~c_nan;
    lt_o = lt_raw & ~c_nan;
  end

  assign s_le = lt_i | eq_i;

  always_comb begin
    y_o = '0;
    case (sp_i.op)
      FEQ:     y_o[0] = eq_i;
      FLT:     y_o[0] = lt_i;
      FLE:     y_o[0] = s_le;
      FMIN:    y_o    = s_le ? sa : sb;
      FMAX:    y_o    = s_le ? sb : sa;
      default: y_o    = '0;
    endcase
`ifdef FCOMP_NAN_EN
    if ((sp_i.op == FMIN) || (sp_i.op == FMAX)) begin
      if (s_na & s_nb) y_o = QNAN;
      else if (s_na)   y_o = sb;
      else if (s_nb)   y_o = sa;
    end
`endif
  end

endmodule

// File: rtl/fcomp_pipe.sv
// Pipelined FP compare/select (FEQ/FLT/FLE/FMIN/FMAX) with valid/ready flow control and
// bubble-collapsing stages. Optional NaN awareness and nv_out under FCOMP_NAN_EN.
module fcomp_pipe
  import fcomp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input logic       clk,
  input logic       rstn,
  fcomp_pipe_if.slave io
);

  localparam int W = fcomp_w(EXP_W, MAN_W);

  logic [STAGES:1] vld_q;
  logic [STAGES:1] adv;

  // A stage moves when any stage from it to the output has a hole, or the consumer takes.
  for (genvar k = 1; k <= STAGES; k++) begin : g_adv
    assign adv[k] = ~(&vld_q[STAGES:k]) | io.out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rstn) vld_q <= '0;
    else begin
      if (adv[1]) vld_q[1] <= io.in_valid;
      for (int k = 2; k <= STAGES; k++)
        if (adv[k]) vld_q[k] <= vld_q[k-1];
    end
  end

  fcomp_pay_t   in_p, cp, sp;
  logic         zc, mlt, eq, lt, seq, slt;
  logic [W-1:0] y_d, y_q;
  logic [TAG_W-1:0] tag_q;

  always_comb begin
    in_p     = '0;
    in_p.op  = io.op;
    in_p.x1  = XW_MAX'(io.x1);
    in_p.x2  = XW_MAX'(io.x2);
    in_p.tag = TAG_MAX'(io.tag_in);
    in_p.zc  = zc;
    in_p.mlt = mlt;
  end

  if (STAGES == 1) begin : g_st1
    assign cp  = in_p;
    assign sp  = in_p;
    assign seq = eq;
    assign slt = lt;
  end else begin : g_stn
    fcomp_pay_t s1_q;
    always_ff @(posedge clk) begin
      if (!rstn)       s1_q <= '0;
      else if (adv[1]) s1_q <= in_p;
    end
    assign cp = s1_q;

    if (STAGES == 2) begin : g_st2
      assign sp  = s1_q;
      assign seq = eq;
      assign slt = lt;
    end else begin : g_st3
      fcomp_pay_t s2_q;
      logic       eq2_q, lt2_q;
      always_ff @(posedge clk) begin
        if (!rstn) begin
          s2_q  <= '0;
          eq2_q <= 1'b0;
          lt2_q <= 1'b0;
        end else if (adv[2]) begin
          s2_q  <= s1_q;
          eq2_q <= eq;
          lt2_q <= lt;
        end
      end
      assign sp  = s2_q;
      assign seq = eq2_q;
      assign slt = lt2_q;
    end
  end

`ifdef FCOMP_NAN_EN
  logic nv_d, nv_q;
`endif

  fcomp_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
    .x1_i (io.x1),
    .x2_i (io.x2),
    .zc_o (zc),
    .mlt_o(mlt),
    .cp_i (cp),
    .eq_o (eq),
    .lt_o (lt),
    .sp_i (sp),
    .eq_i (seq),
    .lt_i (slt),
`ifdef FCOMP_NAN_EN
    .nv_o (nv_d),
`endif
    .y_o  (y_d)
  );

  // Output register only moves on advance, so a stalled result stays put.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      y_q   <= '0;
      tag_q <= '0;
`ifdef FCOMP_NAN_EN
      nv_q  <= 1'b0;
`endif
    end else if (adv[STAGES]) begin
      y_q   <= y_d;
      tag_q <= sp.tag[TAG_W-1:0];
`ifdef FCOMP_NAN_EN
      nv_q  <= nv_d;
`endif
    end
  end

  assign io.in_ready  = adv[1];
  assign io.out_valid = vld_q[STAGES];
  assign io.y         = y_q;
  assign io.tag_out   = tag_q;
`ifdef FCOMP_NAN_EN
  assign io.nv_out    = nv_q;
`endif

endmodule

// File: tb/tb_fcomp_pipe.sv
// Directed scoreboard bench for fcomp_pipe (STAGES=2, single precision).
module tb_fcomp_pipe;
  import fcomp_pkg::*;

  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fcomp_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) io();

  fcomp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(5)) dut (
    .clk (clk),
    .rstn(rstn),
    .io  (io.slave)
  );

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        nv;
    bit          lat;
    int          acc_cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, fails = 0, pops = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", nm, got, want);
    end
  endtask

  // Scoreboard pop at negedge: a transfer happens on the following posedge.
  always @(negedge clk) begin
    if (rstn && io.out_valid && io.out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_output got tag=%h exp none", io.tag_out);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        chk({e.nm, "_y"}, io.y, e.y);
        chk({e.nm, "_tag"}, 32'(io.tag_out), 32'(e.tag));
`ifdef FCOMP_NAN_EN
        chk({e.nm, "_nv"}, 32'(io.nv_out), 32'(e.nv));
`endif
        if (e.lat) chk({e.nm, "_latency"}, 32'(cyc - e.acc_cyc), 32'(STAGES));
      end
    end
  end

  task automatic push(input logic [31:0] ey, input logic [4:0] t, input logic env,
                      input string nm, input bit lat);
    exp_t e;
    e.y = ey; e.tag = t; e.nv = env; e.lat = lat; e.acc_cyc = cyc; e.nm = nm;
    sb.push_back(e);
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [2:0] op_, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input logic [31:0] ey, input logic env,
                      input string nm, input bit lat);
    bit ok;
    ok = 0;
    io.in_valid = 1'b1; io.op = op_; io.x1 = a; io.x2 = b; io.tag_in = t;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (io.in_ready) begin
        push(ey, t, env, nm, lat);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    checks++;
    assert (ok) else begin
      fails++;
      $error("FAIL %s_accept got=timeout exp=accepted", nm);
    end
    io.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic drive_req(input int i);
    io.in_valid = 1'b1;
    io.op       = FEQ;
    io.x1       = 32'h4000_0000 + 32'(i);
    io.x2       = (i % 2 == 1) ? 32'h4000_0000 + 32'(i) : 32'h4040_0000 + 32'(i);
    io.tag_in   = 5'(i);
  endtask

  initial begin
    int acc, p0, n;
    rstn = 1'b0;
    io.in_valid = 1'b0; io.op = '0; io.x1 = '0; io.x2 = '0; io.tag_in = '0;
    io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_y", io.y, 32'd0);
    chk("rst_tag", 32'(io.tag_out), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency on an unstalled pipe
    send(FLT, 32'hBF80_0000, 32'h3F80_0000, 5'd3, 32'd1, 1'b0, "flt_neg_pos", 1'b1);
    drain("lat");

    // Reset while a transaction sits in stage 1
    send(FLT, 32'hBF80_0000, 32'h3F80_0000, 5'd7, 32'd1, 1'b0, "rst_flight", 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    p0 = pops;
    @(negedge clk);
    chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(io.in_ready), 32'd1);
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("midrst_no_emit", 32'(pops - p0), 32'd0);

    // Zero class and magnitude ordering
    send(FEQ,  32'h8000_0000, 32'h0000_0001, 5'd1,  32'd1,         1'b0, "zc_feq",  1'b0);
    send(FLT,  32'h8000_0000, 32'h0000_0001, 5'd2,  32'd0,         1'b0, "zc_flt",  1'b0);
    send(FLE,  32'h8000_0000, 32'h0000_0001, 5'd3,  32'd1,         1'b0, "zc_fle",  1'b0);
    send(FMIN, 32'h8000_0000, 32'h0000_0001, 5'd4,  32'h8000_0000, 1'b0, "zc_fmin", 1'b0);
    send(FMAX, 32'h8000_0000, 32'h0000_0001, 5'd5,  32'h0000_0001, 1'b0, "zc_fmax", 1'b0);
    send(FLT,  32'hC000_0000, 32'hBF80_0000, 5'd6,  32'd1,         1'b0, "neg_flt", 1'b0);
    send(FLE,  32'hC000_0000, 32'hC000_0000, 5'd7,  32'd1,         1'b0, "neg_fle_eq", 1'b0);
    send(FMAX, 32'hC000_0000, 32'hBF80_0000, 5'd8,  32'hBF80_0000, 1'b0, "neg_fmax", 1'b0);
    send(FLT,  32'h4000_0000, 32'h3F80_0000, 5'd9,  32'd0,         1'b0, "pos_flt_gt", 1'b0);
    send(FMIN, 32'h3F80_0000, 32'h4000_0000, 5'd10, 32'h3F80_0000, 1'b0, "pos_fmin", 1'b0);
    send(3'd6, 32'h3F80_0000, 32'h4000_0000, 5'd19, 32'd0,         1'b0, "reserved", 1'b0);
    drain("directed");

    // Backpressure: fill with out_ready low, check stability, then release
    io.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive_req(acc);
      @(negedge clk);
      if (io.in_ready) begin
        push((acc % 2 == 1) ? 32'd1 : 32'd0, 5'(acc), 1'b0, $sformatf("bp%0d", acc), 1'b0);
        acc++;
      end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(acc), 32'(STAGES));
    chk("bp_in_ready", 32'(io.in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(io.out_valid), 32'd1);
      chk("bp_hold_y", io.y, sb[0].y);
      chk("bp_hold_tag", 32'(io.tag_out), 32'(sb[0].tag));
    end
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    p0 = pops;
    n = 0;
    while ((pops - p0) < 6 && n < 40) begin
      if (acc < 6) drive_req(acc);
      else io.in_valid = 1'b0;
      @(negedge clk);
      if (io.in_valid && io.in_ready) begin
        push((acc % 2 == 1) ? 32'd1 : 32'd0, 5'(acc), 1'b0, $sformatf("bp%0d", acc), 1'b0);
        acc++;
      end
      @(posedge clk); #1;
      n++;
    end
    io.in_valid = 1'b0;
    chk("bp_results", 32'(pops - p0), 32'd6);
    chk("bp_cycles", 32'(n), 32'd6);

    // NaN patterns: NaN-aware build vs plain magnitude compare
    send(FMIN, 32'h7FC0_0000, 32'h3F80_0000, 5'd11, 32'h3F80_0000, 1'b0, "nan_fmin", 1'b0);
    send(FLT,  32'h7F80_0001, 32'h0000_0000, 5'd12, 32'd0,         1'b1, "snan_flt", 1'b0);
`ifdef FCOMP_NAN_EN
    send(FMAX, 32'h7F80_0001, 32'hFFC0_0000, 5'd13, 32'h7FC0_0000, 1'b1, "nan2_fmax", 1'b0);
    send(FEQ,  32'h7FC0_0000, 32'h7FC0_0000, 5'd14, 32'd0,         1'b0, "qnan_feq", 1'b0);
`else
    send(FMAX, 32'h7F80_0001, 32'hFFC0_0000, 5'd13, 32'h7F80_0001, 1'b0, "nan2_fmax", 1'b0);
    send(FEQ,  32'h7FC0_0000, 32'h7FC0_0000, 5'd14, 32'd1,         1'b0, "qnan_feq", 1'b0);
`endif
    drain("nan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
